// File: rtl/mm_pkg.sv
`default_nettype none
// ============================================================================
// Package     : mm_pkg
// Description : Shared types and constants for the Mastermind core
//               (turn tracker, comparator, display path).
// Revision    : 1.0 - initial release
// ============================================================================
package mm_pkg;

  // Game-progress controller states.
  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_PLAY  = 2'd1,
    ST_WIN   = 2'd2,
    ST_LOSE  = 2'd3
  } state_e;

  // Encoding of the game_over output.
  localparam logic [1:0] GAME_PLAYING = 2'd0;
  localparam logic [1:0] GAME_LOSE    = 2'd1;
  localparam logic [1:0] GAME_WIN     = 2'd2;

  // Game dimensions shared by all blocks of the core.
  localparam int DEFAULT_MAX_TURNS = 10;
  localparam int DEFAULT_PEGS      = 4;

endpackage : mm_pkg
`default_nettype wire

// File: rtl/feedback_history.sv
`default_nettype none
// ============================================================================
// Module      : feedback_history
// Description : Per-turn feedback store. One write port, a bulk clear of the
//               valid bits, and a registered read port that returns zero for
//               unwritten or out-of-range entries.
// Revision    : 1.0 - initial release
// ============================================================================
module feedback_history #(
  parameter int DEPTH  = 10,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 6
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              clear_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  valid_q;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] rdata_d;

  // Entry storage: clear/reset only drop valid bits; data is qualified by them.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      valid_q <= '0;
    end else if (clear_i) begin
      valid_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (we_i && (waddr_i == ADDR_W'(i))) begin
          valid_q[i] <= 1'b1;
          mem_q[i]   <= wdata_i;
        end
      end
    end
  end

  // Read mux; an address beyond DEPTH matches no entry and yields zero.
  always_comb begin
    rdata_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((raddr_i == ADDR_W'(i)) && valid_q[i]) begin
        rdata_d = mem_q[i];
      end
    end
  end

  // Read register: sees contents from before any write on the same edge.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;

endmodule : feedback_history
`default_nettype wire

// File: rtl/turn_tracker.sv
`default_nettype none
// ============================================================================
// Module      : turn_tracker
// Description : Mastermind game-progress controller. Counts turns, accepts
//               comparator feedback via valid/ready, checks legality,
//               detects win/lose and keeps a readable feedback history.
// Revision    : 1.0 - initial release
// ============================================================================
module turn_tracker
  import mm_pkg::*;
#(
  parameter int MAX_TURNS = DEFAULT_MAX_TURNS,
  parameter int PEGS      = DEFAULT_PEGS,
  parameter int TURN_W    = 4,
  parameter int FB_W      = 3
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              new_game,
  input  logic              fb_valid,
  output logic              fb_ready,
  input  logic [FB_W-1:0]   fb_exact,
  input  logic [FB_W-1:0]   fb_partial,
  output logic [TURN_W-1:0] current_turn,
  output logic [1:0]        game_over,
  output logic              fb_error,
  input  logic [TURN_W-1:0] hist_rd_addr,
  output logic [2*FB_W-1:0] hist_rd_data
);

  localparam logic [FB_W:0]     c_PEGS     = (FB_W+1)'(PEGS);
  localparam logic [TURN_W-1:0] c_MAX_TURN = TURN_W'(MAX_TURNS);
  localparam logic [TURN_W-1:0] c_TURN_ONE = TURN_W'(1);

  state_e            state_q, state_d;
  logic [TURN_W-1:0] turn_q, turn_d;
  logic              fb_error_q, fb_error_d;

  logic [FB_W:0]     w_fb_sum;
  logic              w_legal;
  logic              w_win;
  logic              w_handshake;
  logic              w_hist_we;
  logic [TURN_W-1:0] w_hist_waddr;

  // Sum is one bit wider than the counts so 7+7 cannot wrap into range.
  assign w_fb_sum     = {1'b0, fb_exact} + {1'b0, fb_partial};
  assign w_legal      = ({1'b0, fb_exact} <= c_PEGS) && (w_fb_sum <= c_PEGS);
  assign w_win        = ({1'b0, fb_exact} == c_PEGS);
  assign w_handshake  = fb_valid && fb_ready;
  assign w_hist_we    = w_handshake && w_legal;
  assign w_hist_waddr = turn_q - c_TURN_ONE;

  // Next-state, turn counter and decoded outputs; new_game wins over all.
  always_comb begin
    state_d    = state_q;
    turn_d     = turn_q;
    fb_error_d = 1'b0;
    fb_ready   = (state_q == ST_PLAY) && !new_game;
    game_over  = GAME_PLAYING;

    case (state_q)
      ST_WIN:  game_over = GAME_WIN;
      ST_LOSE: game_over = GAME_LOSE;
      default: game_over = GAME_PLAYING;
    endcase

    if (new_game) begin
      state_d = ST_START;
      turn_d  = '0;
    end else begin
      case (state_q)
        ST_START: begin
          state_d = ST_PLAY;
          turn_d  = c_TURN_ONE;
        end
        ST_PLAY: begin
          if (w_handshake) begin
            if (!w_legal) begin
              fb_error_d = 1'b1;
            end else if (w_win) begin
              state_d = ST_WIN;
            end else if (turn_q == c_MAX_TURN) begin
              state_d = ST_LOSE;
            end else begin
              turn_d = turn_q + c_TURN_ONE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // State, turn and error-pulse registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= ST_START;
      turn_q     <= '0;
      fb_error_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      turn_q     <= turn_d;
      fb_error_q <= fb_error_d;
    end
  end

  assign current_turn = turn_q;
  assign fb_error     = fb_error_q;

  feedback_history #(
    .DEPTH  (MAX_TURNS),
    .ADDR_W (TURN_W),
    .DATA_W (2*FB_W)
  ) u_history (
    .clk     (clk),
    .resetn  (resetn),
    .clear_i (new_game),
    .we_i    (w_hist_we),
    .waddr_i (w_hist_waddr),
    .wdata_i ({fb_exact, fb_partial}),
    .raddr_i (hist_rd_addr),
    .rdata_o (hist_rd_data)
  );

endmodule : turn_tracker
`default_nettype wire

// File: tb/tb_turn_tracker.sv
`default_nettype none
// ============================================================================
// Module      : tb_turn_tracker
// Description : Directed, table-driven bench for turn_tracker with default
//               parameters (MAX_TURNS=10, PEGS=4, TURN_W=4, FB_W=3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_turn_tracker;

  typedef struct {
    logic       ng;
    logic       v;
    logic [2:0] ex;
    logic [2:0] pa;
    logic [3:0] ra;
    logic [3:0] e_turn;
    logic [1:0] e_go;
    logic       e_rdy;
    logic       e_err;
    logic [5:0] e_rd;
  } vec_t;

  logic       clk;
  logic       resetn;
  logic       new_game;
  logic       fb_valid;
  logic       fb_ready;
  logic [2:0] fb_exact;
  logic [2:0] fb_partial;
  logic [3:0] current_turn;
  logic [1:0] game_over;
  logic       fb_error;
  logic [3:0] hist_rd_addr;
  logic [5:0] hist_rd_data;

  int n_checks   = 0;
  int n_failures = 0;

  turn_tracker dut (
    .clk          (clk),
    .resetn       (resetn),
    .new_game     (new_game),
    .fb_valid     (fb_valid),
    .fb_ready     (fb_ready),
    .fb_exact     (fb_exact),
    .fb_partial   (fb_partial),
    .current_turn (current_turn),
    .game_over    (game_over),
    .fb_error     (fb_error),
    .hist_rd_addr (hist_rd_addr),
    .hist_rd_data (hist_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(int ng, int v, int ex, int pa, int ra,
                              int t, int go, int rdy, int err, int rd);
    vec_t r;
    r.ng = 1'(ng);  r.v = 1'(v);  r.ex = 3'(ex);  r.pa = 3'(pa);
    r.ra = 4'(ra);  r.e_turn = 4'(t);  r.e_go = 2'(go);
    r.e_rdy = 1'(rdy);  r.e_err = 1'(err);  r.e_rd = 6'(rd);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input vec_t t);
    chk($sformatf("%s.turn", tag), 32'(current_turn), 32'(t.e_turn));
    chk($sformatf("%s.game_over", tag), 32'(game_over), 32'(t.e_go));
    chk($sformatf("%s.fb_ready", tag), 32'(fb_ready), 32'(t.e_rdy));
    chk($sformatf("%s.fb_error", tag), 32'(fb_error), 32'(t.e_err));
    chk($sformatf("%s.hist_rd_data", tag), 32'(hist_rd_data), 32'(t.e_rd));
  endtask

  // Drive one cycle of inputs at the falling edge, check after the rising edge.
  task automatic apply(input vec_t t, input string tag);
    @(negedge clk);
    new_game     = t.ng;
    fb_valid     = t.v;
    fb_exact     = t.ex;
    fb_partial   = t.pa;
    hist_rd_addr = t.ra;
    @(posedge clk);
    #1;
    check_all(tag, t);
  endtask

  vec_t tbl [23];

  initial begin
    //            ng v  ex pa ra  turn go rdy err rd
    tbl[0]  = mk(0, 0, 0, 0, 0,   1,  0, 1,  0, 'h00); // START -> PLAY turn 1
    tbl[1]  = mk(0, 1, 1, 2, 0,   2,  0, 1,  0, 'h00);
    tbl[2]  = mk(0, 1, 0, 0, 0,   3,  0, 1,  0, 'h0A);
    tbl[3]  = mk(0, 1, 2, 2, 1,   4,  0, 1,  0, 'h00);
    tbl[4]  = mk(0, 1, 4, 0, 2,   4,  2, 0,  0, 'h12); // win on turn 4
    tbl[5]  = mk(0, 0, 0, 0, 3,   4,  2, 0,  0, 'h20);
    tbl[6]  = mk(0, 0, 0, 0, 4,   4,  2, 0,  0, 'h00);
    tbl[7]  = mk(0, 1, 1, 1, 0,   4,  2, 0,  0, 'h0A); // valid ignored in WIN
    tbl[8]  = mk(1, 0, 0, 0, 0,   0,  0, 0,  0, 'h0A); // new_game from WIN
    tbl[9]  = mk(0, 0, 0, 0, 0,   1,  0, 1,  0, 'h00);
    tbl[10] = mk(0, 1, 3, 0, 0,   2,  0, 1,  0, 'h00);
    tbl[11] = mk(0, 1, 3, 2, 1,   2,  0, 1,  1, 'h00); // sum 5 illegal
    tbl[12] = mk(0, 0, 0, 0, 1,   2,  0, 1,  0, 'h00);
    tbl[13] = mk(0, 1, 5, 0, 1,   2,  0, 1,  1, 'h00); // exact 5 illegal
    tbl[14] = mk(0, 0, 0, 0, 1,   2,  0, 1,  0, 'h00);
    tbl[15] = mk(0, 1, 0, 4, 0,   3,  0, 1,  0, 'h18); // sum 4 legal
    tbl[16] = mk(0, 1, 7, 7, 1,   3,  0, 1,  1, 'h04); // 7+7 must not wrap
    tbl[17] = mk(0, 1, 1, 1, 2,   4,  0, 1,  0, 'h00);
    tbl[18] = mk(0, 1, 1, 1, 2,   5,  0, 1,  0, 'h09);
    tbl[19] = mk(0, 1, 0, 1, 15,  6,  0, 1,  0, 'h00); // out-of-range read
    tbl[20] = mk(1, 1, 2, 0, 0,   0,  0, 0,  0, 'h18); // new_game beats valid
    tbl[21] = mk(0, 0, 0, 0, 1,   1,  0, 1,  0, 'h00);
    tbl[22] = mk(0, 0, 0, 0, 4,   1,  0, 1,  0, 'h00);

    resetn       = 1'b0;
    new_game     = 1'b0;
    fb_valid     = 1'b0;
    fb_exact     = '0;
    fb_partial   = '0;
    hist_rd_addr = '0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    resetn = 1'b1;

    for (int i = 0; i < 23; i++) begin
      apply(tbl[i], $sformatf("tbl%0d", i));
    end

    // Ten legal misses: LOSE after the tenth.
    apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 'h00), "lose.ng");
    apply(mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 'h00), "lose.start");
    for (int i = 1; i <= 10; i++) begin
      apply(mk(0, 1, 0, 3, 0, (i < 10) ? i + 1 : 10, (i == 10) ? 1 : 0,
               (i < 10) ? 1 : 0, 0, (i == 1) ? 'h00 : 'h03),
            $sformatf("lose.t%0d", i));
    end
    apply(mk(0, 1, 4, 0, 9,  10, 1, 0, 0, 'h03), "lose.hold9");
    apply(mk(0, 0, 0, 0, 10, 10, 1, 0, 0, 'h00), "lose.rd10");
    apply(mk(1, 0, 0, 0, 0,  0,  0, 0, 0, 'h03), "lose.ng2");
    apply(mk(0, 0, 0, 0, 0,  1,  0, 1, 0, 'h00), "lose.restart");

    // Win on the final turn takes priority over lose.
    for (int i = 1; i <= 10; i++) begin
      apply(mk(0, 1, (i == 10) ? 4 : 0, 0, 0, (i < 10) ? i + 1 : 10,
               (i == 10) ? 2 : 0, (i < 10) ? 1 : 0, 0, 'h00),
            $sformatf("win10.t%0d", i));
    end

    // fb_valid held for three cycles: three accepted turns.
    apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 'h00), "hold.ng");
    apply(mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 'h00), "hold.start");
    for (int i = 0; i < 3; i++) begin
      apply(mk(0, 1, 1, 0, 0, i + 2, 0, 1, 0, (i == 0) ? 'h00 : 'h08),
            $sformatf("hold.c%0d", i));
    end
    apply(mk(0, 0, 0, 0, 2, 4, 0, 1, 0, 'h08), "hold.rd2");

    // Mid-game reset: START on the next edge, history cleared.
    resetn = 1'b0;
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 'h00), "rst.mid");
    resetn = 1'b1;
    apply(mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 'h00), "rst.play");
    apply(mk(0, 0, 0, 0, 2, 1, 0, 1, 0, 'h00), "rst.rd2");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
    $finish;
  end

endmodule : tb_turn_tracker
`default_nettype wire
